// File: rtl/serial_exec_unit.sv
// Bit-serial execute stage: one 16-bit instruction per handshake. Operands are
// shifted LSB-first through a 1-bit ALU with a carry flop, then written back.
module serial_exec_unit #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             illegal,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WRITE
    } state_t;

    state_t state, state_nx;

    logic [15:0]      ir;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_r;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic load_en;
    logic shift_en;
    logic write_en;
    logic last_bit;
    logic alu_bit;
    logic alu_co;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm8;

    assign op   = ir[15:12];
    assign rd   = ir[11:10];
    assign rs   = ir[9:8];
    assign imm8 = ir[7:0];

    function automatic logic is_arith(input logic [3:0] code);
        return (code == OP_ADD) || (code == OP_SUB) || (code == OP_ADDI);
    endfunction

    function automatic logic is_write(input logic [3:0] code);
        return (code >= OP_LDI) && (code <= OP_MOV);
    endfunction

    // One serial ALU step: returns {carry_out, result_bit}. Non-arithmetic
    // ops pass the incoming carry through so the flop holds.
    function automatic logic [1:0] alu_step(input logic [3:0] code,
                                            input logic a, input logic b,
                                            input logic cin);
        logic bit_o;
        logic cout;
        bit_o = 1'b0;
        cout  = cin;
        case (code)
            OP_ADD, OP_SUB, OP_ADDI: begin
                bit_o = a ^ b ^ cin;
                cout  = (a & b) | (a & cin) | (b & cin);
            end
            OP_AND:         bit_o = a & b;
            OP_OR:          bit_o = a | b;
            OP_XOR:         bit_o = a ^ b;
            OP_LDI, OP_MOV: bit_o = a | b;
            default:        bit_o = 1'b0;
        endcase
        return {cout, bit_o};
    endfunction

    assign {alu_co, alu_bit} = alu_step(op, sh_a[0], sh_b[0], carry);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (instr_valid) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_SHIFT;
            S_SHIFT: if (last_bit) state_nx = S_WRITE;
            S_WRITE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == S_IDLE);
        load_en  = (state == S_LOAD);
        shift_en = (state == S_SHIFT);
        write_en = (state == S_WRITE);
        accept   = (state == S_IDLE) && instr_valid;
    end

    // Operand shifters, carry and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir    <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_r  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                ir <= instr;
            end
            if (load_en) begin
                sh_a  <= ((op == OP_LDI) || (op == OP_MOV)) ? '0 : regs[rd];
                if ((op == OP_LDI) || (op == OP_ADDI)) begin
                    sh_b <= WIDTH'(imm8);
                end else if (op == OP_SUB) begin
                    sh_b <= ~regs[rs];
                end else begin
                    sh_b <= regs[rs];
                end
                carry <= (op == OP_SUB);
                cnt   <= '0;
            end
            if (shift_en) begin
                sh_r  <= {alu_bit, sh_r[WIDTH-1:1]};
                sh_a  <= sh_a >> 1;
                sh_b  <= sh_b >> 1;
                carry <= alu_co;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    // Writeback: register file, result and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            done    <= 1'b0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= write_en;
            if (write_en) begin
                illegal <= (op >= 4'd9);
                if (is_write(op)) begin
                    regs[rd] <= sh_r;
                    result   <= sh_r;
                    flag_z   <= (sh_r == '0);
                end
                if (is_arith(op)) begin
                    flag_c <= carry;
                end
            end
        end
    end

    assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_serial_exec_unit.sv
// Directed and random checks of serial_exec_unit against an arithmetic model.
module tb_serial_exec_unit;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] LDI  = 4'd1;
    localparam logic [3:0] ADD  = 4'd2;
    localparam logic [3:0] SUB  = 4'd3;
    localparam logic [3:0] ANDO = 4'd4;
    localparam logic [3:0] ORO  = 4'd5;
    localparam logic [3:0] XORO = 4'd6;
    localparam logic [3:0] ADDI = 4'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        ready;
    logic        done;
    logic [7:0]  result;
    logic        flag_z;
    logic        flag_c;
    logic        illegal;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] m_reg [4];
    logic [7:0] m_res;
    logic       m_z, m_c, m_ill;

    serial_exec_unit #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .ready(ready), .done(done), .result(result), .flag_z(flag_z),
        .flag_c(flag_c), .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_res = 8'h00; m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0;
    endtask

    // Architectural effect of one instruction, in plain arithmetic.
    task automatic model_exec(input logic [15:0] ins);
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [7:0] imm, a, b, w;
        logic       c;
        int         s;
        op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
        a = m_reg[rd]; b = m_reg[rs]; w = 8'h00; c = m_c;
        case (op)
            4'd1: w = imm;
            4'd2: begin s = int'(a) + int'(b); w = 8'(s); c = (s > 255); end
            4'd3: begin w = a - b; c = (a >= b); end
            4'd4: w = a & b;
            4'd5: w = a | b;
            4'd6: w = a ^ b;
            4'd7: begin s = int'(a) + int'(imm); w = 8'(s); c = (s > 255); end
            4'd8: w = b;
            default: w = 8'h00;
        endcase
        if (op >= 4'd1 && op <= 4'd8) begin
            m_reg[rd] = w; m_res = w; m_z = (w == 8'h00); m_c = c;
        end
        m_ill = (op >= 4'd9);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk8($sformatf("%s_r%0d", tag, i), dbg_data, m_reg[i]);
        end
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "_ready"}, ready, 1'b1);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_z"}, flag_z, 1'b0);
        chk1({tag, "_c"}, flag_c, 1'b0);
        chk1({tag, "_ill"}, illegal, 1'b0);
        chk8({tag, "_result"}, result, 8'h00);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk8($sformatf("%s_dbg%0d", tag, i), dbg_data, 8'h00);
        end
    endtask

    // Issue one instruction; optionally pulse another while busy at cycle T+inj_at.
    task automatic exec(input logic [15:0] ins, input int inj_at, input logic [15:0] inj);
        int k;
        int first;
        k = 0;
        while (!ready && k < 30) begin @(posedge clk); #1; k++; end
        chk1("ready_before_issue", ready, 1'b1);
        instr = ins; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        first = 0;
        for (k = 1; k <= 25; k++) begin
            if (done) begin first = k; break; end
            if (inj_at > 0 && k == inj_at) begin instr_valid = 1'b1; instr = inj; end
            if (inj_at > 0 && k == inj_at + 1) instr_valid = 1'b0;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        chki($sformatf("latency_%h", ins), first, 11);
        chk1("ready_with_done", ready, 1'b1);
        model_exec(ins);
        chk8($sformatf("result_%h", ins), result, m_res);
        chk1($sformatf("z_%h", ins), flag_z, m_z);
        chk1($sformatf("c_%h", ins), flag_c, m_c);
        chk1($sformatf("illegal_%h", ins), illegal, m_ill);
        check_regs($sformatf("regs_%h", ins));
        @(posedge clk); #1;
        chk1("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int acc [3];
        int n;
        int k;
        bit go;
        logic [15:0] ri;

        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000; dbg_sel = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_idle");

        // Populate state, then reset in the middle of ADD r0,r1
        exec(mk(LDI, 2'd0, 2'd0, 8'hFF), 0, 16'h0);
        exec(mk(LDI, 2'd1, 2'd0, 8'h01), 0, 16'h0);
        exec(mk(ADD, 2'd0, 2'd1, 8'h00), 0, 16'h0);
        instr = mk(ADD, 2'd0, 2'd1, 8'h00); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_reset("rst_after");

        exec(mk(LDI, 2'd0, 2'd0, 8'h7F), 0, 16'h0);
        exec(mk(LDI, 2'd1, 2'd0, 8'h81), 0, 16'h0);
        exec(mk(ADD, 2'd0, 2'd1, 8'h00), 0, 16'h0);
        chk8("add_wrap_result", result, 8'h00);
        chk1("add_wrap_z", flag_z, 1'b1);
        chk1("add_wrap_c", flag_c, 1'b1);

        exec(mk(LDI, 2'd2, 2'd0, 8'h05), 0, 16'h0);
        exec(mk(LDI, 2'd3, 2'd0, 8'h09), 0, 16'h0);
        exec(mk(SUB, 2'd2, 2'd3, 8'h00), 0, 16'h0);
        chk8("sub_borrow_result", result, 8'hFC);
        chk1("sub_borrow_c", flag_c, 1'b0);
        chk1("sub_borrow_z", flag_z, 1'b0);
        exec(mk(SUB, 2'd3, 2'd3, 8'h00), 0, 16'h0);
        chk8("sub_self_result", result, 8'h00);
        chk1("sub_self_z", flag_z, 1'b1);
        chk1("sub_self_c", flag_c, 1'b1);

        exec(mk(LDI, 2'd0, 2'd0, 8'hF0), 0, 16'h0);
        exec(mk(LDI, 2'd1, 2'd0, 8'h3C), 0, 16'h0);
        exec(mk(ANDO, 2'd0, 2'd1, 8'h00), 0, 16'h0);
        chk8("and_result", result, 8'h30);
        chk1("and_c_hold", flag_c, 1'b1);
        exec(mk(LDI, 2'd0, 2'd0, 8'hF0), 0, 16'h0);
        exec(mk(ORO, 2'd0, 2'd1, 8'h00), 0, 16'h0);
        chk8("or_result", result, 8'hFC);
        chk1("or_c_hold", flag_c, 1'b1);
        exec(mk(XORO, 2'd1, 2'd1, 8'h00), 0, 16'h0);
        chk8("xor_result", result, 8'h00);
        chk1("xor_z", flag_z, 1'b1);
        chk1("xor_c_hold", flag_c, 1'b1);

        exec(mk(ADDI, 2'd0, 2'd0, 8'h01), 4, mk(LDI, 2'd1, 2'd0, 8'hAA));
        dbg_sel = 2'd0; #1;
        chk8("busy_r0_incr", dbg_data, 8'hFD);
        dbg_sel = 2'd1; #1;
        chk8("busy_r1_kept", dbg_data, 8'h00);
        exec(mk(4'hC, 2'd2, 2'd3, 8'h55), 0, 16'h0);
        chk1("illegal_set", illegal, 1'b1);
        exec(mk(NOP, 2'd0, 2'd0, 8'h00), 0, 16'h0);
        chk1("illegal_clear", illegal, 1'b0);

        // Back-to-back with instr_valid held high
        acc[0] = 0; acc[1] = 0; acc[2] = 0; n = 0;
        instr = mk(LDI, 2'd0, 2'd0, 8'h11); instr_valid = 1'b1;
        for (int j = 0; j < 60 && n < 3; j++) begin
            go = ready && instr_valid;
            if (go) acc[n] = cyc;
            @(posedge clk); #1;
            if (go) begin
                n++;
                if (n == 1) instr = mk(LDI, 2'd1, 2'd0, 8'h22);
                else if (n == 2) instr = mk(LDI, 2'd2, 2'd0, 8'h33);
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        chki("b2b_accepts", n, 3);
        chki("b2b_gap1", acc[1] - acc[0], 11);
        chki("b2b_gap2", acc[2] - acc[1], 11);
        k = 0;
        while (!done && k < 20) begin @(posedge clk); #1; k++; end
        chk1("b2b_done", done, 1'b1);
        model_exec(mk(LDI, 2'd0, 2'd0, 8'h11));
        model_exec(mk(LDI, 2'd1, 2'd0, 8'h22));
        model_exec(mk(LDI, 2'd2, 2'd0, 8'h33));
        check_regs("b2b");
        chk8("b2b_r0_const", m_reg[0], 8'h11);

        for (int i = 0; i < 40; i++) begin
            ri = 16'($urandom);
            if (i % 4 != 3) ri[15:12] = 4'($urandom_range(0, 8));
            exec(ri, 0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_exec_unit.md
# serial_exec_unit

Bit-serial execute stage of the CPU. It sits directly downstream of the two-byte DIP-switch instruction loader and takes one complete 16-bit instruction per handshake. Operands from a 4×8-bit register file (or the immediate) are shifted LSB-first through a 1-bit ALU with a carry flop. The result is written back to the register file and the Z/C flags are updated. A read port exposes any register for the LED / 7-segment display.

## Interface
Parameters:
- WIDTH, 8, datapath width and number of serial shift cycles
- NREGS, 4, register file depth (instruction field sized for 4)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- instr  in  16  instruction from the loader, sampled on accept
- instr_valid  in  1  instruction present; accepted when `instr_valid & ready` at a clk edge
- ready  out  1  idle and able to accept
- done  out  1  one-cycle pulse after writeback
- result  out  8  value of the last executed instruction's result, registered
- flag_z  out  1  zero flag
- flag_c  out  1  carry / no-borrow flag
- illegal  out  1  last executed opcode was undefined
- dbg_sel  in  2  register select for the display read port
- dbg_data  out  8  combinational `regfile[dbg_sel]`

## Operation
Instruction fields:
- `[15:12]` opcode
- `[11:10]` rd
- `[9:8]` rs
- `[7:0]` imm8

Opcodes:
- 0 NOP: no write.
- 1 LDI: `rd <= imm8`.
- 2 ADD: `rd <= rd + rs`.
- 3 SUB: `rd <= rd + ~rs + 1`.
- 4 AND, 5 OR, 6 XOR: `rd <= rd op rs`.
- 7 ADDI: `rd <= rd + imm8`.
- 8 MOV: `rd <= rs`.
- 9–15: illegal. Treated as NOP and set `illegal`.

Operand and carry setup in LOAD:
- Shift reg A = `regfile[rd]`. For LDI and MOV, A = 0.
- Shift reg B = `regfile[rs]`. For LDI and ADDI, B = imm8. For SUB, B = `~regfile[rs]`.
- Carry flop = 1 for SUB, 0 otherwise.

Each SHIFT cycle:
- Compute the bit from `A[0]`, `B[0]` and the carry.
- `R <= {bit, R[7:1]}`, and shift A and B right.
- Carry updates only for arithmetic ops (ADD, SUB, ADDI).
- LDI and MOV output `A[0] | B[0]`.

State machine:
- IDLE: `ready`=1. On accept, latch the instruction and go to LOAD.
- LOAD: fill A, B and the carry. Go to SHIFT.
- SHIFT: exactly WIDTH cycles, counted by a 3-bit counter that wraps 7→0. Go to WRITE.
- WRITE: commit the result (rules below). Go to IDLE.

WRITE rules:
- For writing ops: `regfile[rd] <= R` and `result <= R`. `flag_z <= (R==0)`.
- `flag_c <= carry` only for ADD, SUB and ADDI. Otherwise `flag_c` holds.
- NOP and illegal: regfile, `result` and flags unchanged.
- `illegal <=` (opcode ≥ 9). This is updated on every instruction, so a legal instruction clears it.

Boundary conditions:
- `instr_valid` while busy is ignored; there is no queue. `instr` changes while busy have no effect.
- rd == rs is legal; both operands are read in LOAD before any write.
- ADD overflow wraps mod 256 and sets C.
- SUB borrow gives C=0. Equal operands give C=1, Z=1.
- Reset mid-operation aborts the instruction with no partial write, and everything returns to reset values.

## Timing
- Reset values:
  - `ready`=1.
  - `done`=0, `result`=0x00.
  - `flag_z`=0, `flag_c`=0, `illegal`=0.
  - All registers = 0x00, so `dbg_data`=0x00.
  - State = IDLE.
- Accept at edge T:
  - `ready`=0 during cycles T+1 … T+10.
  - LOAD is cycle T+1, SHIFT is T+2 … T+9, WRITE is T+10.
  - Regfile, `result` and flags are visible from cycle T+11.
  - `done`=1 for exactly cycle T+11, with `ready`=1 in the same cycle.
- Latency is 11 cycles from accept to `done` for every opcode, including NOP and illegal.
- Back-to-back: an instruction presented in cycle T+11 is accepted at edge T+11, for a throughput of one instruction per 11 cycles.
- `dbg_data` reflects a write from the cycle after WRITE, and is combinational on `dbg_sel`.

## Test plan
- Reset: assert `rst_n`=0 mid-SHIFT of `ADD r0,r1`, then release. Required: `ready`=1, `done`=0, all flags 0, and `dbg_data`=0x00 for `dbg_sel` = 0..3.
- Load/add: LDI r0,0x7F then LDI r1,0x81 then ADD r0,r1. Required: r0=0x00, Z=1, C=1, `result`=0x00, and `done` exactly 11 cycles after each accept.
- Subtract: r2=0x05, r3=0x09, then SUB r2,r3. Required: r2=0xFC, C=0, Z=0. Then SUB r3,r3. Required: r3=0x00, Z=1, C=1.
- Logic and flag hold: r0=0xF0, r1=0x3C, carry previously 1. AND r0,r1 gives 0x30. OR gives 0xFC. XOR r1,r1 gives 0x00 with Z=1. C stays 1 throughout.
- Busy/illegal: pulse `instr_valid` with LDI r1,0xAA at cycle T+4 of an ADDI r0,0x01. Required: ignored; r1 unchanged; r0 incremented. Then opcode 0xC. Required: `illegal`=1 and no register or flag change. Then NOP. Required: `illegal`=0.
- Back-to-back: hold `instr_valid`=1 across 3 LDIs to r0..r2 (0x11, 0x22, 0x33). Required: accepts exactly 11 cycles apart, and the final regfile reads 0x11, 0x22, 0x33 via `dbg_sel`.
